rob_circ: RTL and testbench
===========================

ROB_CIRC -- requirements
Module: rob_circ

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-002 Parameter DATA_W, default 64, width of value and destination fields.
REQ-003 Parameter OP_W, default 6, width of the opcode field; TAG_W = clog2(DEPTH), derived.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 alloc_valid  in  1  dispatch requests a new entry.
REQ-007 alloc_ready  out  1  entry can be accepted; equals !full.
REQ-008 alloc_op / alloc_dst / alloc_dst_type  in  OP_W / DATA_W / 2  opcode, destination, type (0 none, 1 register, 2 memory, 3 reserved).
REQ-009 alloc_tag  out  TAG_W  index the next accepted entry receives (tail).
REQ-010 cdb_valid / cdb_tag / cdb_data / cdb_mispredict  in  1 / TAG_W / DATA_W / 1  writeback: valid, target entry, result, branch-mispredict flag.
REQ-011 commit_reg_valid  out  1  head retires to the register file this cycle.
REQ-012 commit_store_valid  out  1  head is a store awaiting the memory unit.
REQ-013 store_ready  in  1  memory unit accepts the store.
REQ-014 commit_dst / commit_data  out  DATA_W each  head destination and value.
REQ-015 flush  out  1  mispredicted branch retiring; all entries discarded.
REQ-016 count  out  TAG_W+1  occupied entries; empty / full  out  1 each.

Function
REQ-017 Storage is circular, head and tail pointers of TAG_W bits, wrapping modulo DEPTH.
REQ-018 Allocation at an edge with alloc_valid && alloc_ready: write the fields at tail, clear ready and mispredict, mark occupied, advance tail.
REQ-019 alloc_valid while full is ignored; no state change, no error.
REQ-020 CDB write at an edge with cdb_valid to an occupied entry: store cdb_data, set ready, latch cdb_mispredict; writes to unoccupied entries are ignored.
REQ-021 Commit outputs are combinational from head state; nothing is asserted when empty or head not ready.
REQ-022 Head ready, type 1: commit_reg_valid=1, retire at the edge (head advance, entry freed).
REQ-023 Head ready, type 2: commit_store_valid=1, held with stable commit_dst/commit_data until store_ready; retire at the edge where both are high.
REQ-024 Head ready, type 0 or 3, mispredict clear: retire silently; mispredict set: flush=1 for that cycle.
REQ-025 Flush edge: all entries freed, head=tail=0, count=0; a simultaneous allocation and CDB write are discarded.
REQ-026 At most one retire per cycle; simultaneous allocate and retire leave count unchanged; full is computed from registered count, so a full ROB does not accept in the cycle it retires.
REQ-027 count, empty, full reflect registered state only.

Reset
REQ-028 rst high: head=tail=0, count=0, all entries unoccupied with ready/mispredict cleared, empty=1, full=0, alloc_ready=1, all commit valids and flush 0, commit_dst/commit_data 0.
REQ-029 rst asserted mid-operation discards all in-flight entries, including a store held on store_ready.

Configuration
REQ-030 Macro ROB_CDB_BYPASS_EN defined: a CDB write to the head entry makes it committable in the same cycle, with commit_data=cdb_data and mispredict taken from cdb_mispredict.
REQ-031 Macro undefined: the head entry commits no earlier than the cycle after its CDB write.

Verification (DEPTH=4, DATA_W=64)
REQ-032 Allocate 4 type-1 entries, no CDB -> full=1, alloc_ready=0, count=4; 5th alloc_valid ignored, tail unchanged.
REQ-033 Allocate tags 0,1; CDB tag1=0xBB then tag0=0xAA -> commit_reg_valid cycles retire tag0 data 0xAA, then tag1 data 0xBB, in order.
REQ-034 Type-2 head ready, dst 0x100, value 0x55, store_ready low 3 cycles -> commit_store_valid held 3 cycles, stable outputs; retires on the store_ready edge.
REQ-035 Type-0 head written with cdb_mispredict=1, 2 younger entries, alloc_valid in the flush cycle -> flush one cycle; next cycle count=0, empty=1, alloc_tag=0.
REQ-036 Fill/retire 10 entries continuously -> tags wrap 3->0; count never exceeds 4; data order preserved.
REQ-037 Assert rst while a store waits -> all outputs at reset values immediately; after release count=0.

Source files
------------

// File: rtl/rob_circ.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rob_circ                                                      |
// | Purpose  : Circular reorder buffer. Entries are allocated in order at    |
// |            tail, completed out of order by CDB writebacks and retired    |
// |            in order from head (register write, store handshake, silent   |
// |            retire or mispredict flush).                                  |
// | Options  : ROB_CDB_BYPASS_EN - a CDB write to the head entry makes it    |
// |            committable in the same cycle.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rob_circ #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int OP_W   = 6,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [OP_W-1:0]   alloc_op,
  input  logic [DATA_W-1:0] alloc_dst,
  input  logic [1:0]        alloc_dst_type,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  output logic              commit_reg_valid,
  output logic              commit_store_valid,
  input  logic              store_ready,
  output logic [DATA_W-1:0] commit_dst,
  output logic [DATA_W-1:0] commit_data,
  output logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [1:0]   c_TYPE_REG   = 2'd1;
  localparam logic [1:0]   c_TYPE_STORE = 2'd2;
  localparam logic [TAG_W:0] c_FULL     = (TAG_W+1)'(DEPTH);

  // Entry payload (no reset needed: only observed while the entry is occupied)
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [DATA_W-1:0] r_dst  [DEPTH];
  logic [1:0]        r_type [DEPTH];
  logic [DATA_W-1:0] r_val  [DEPTH];
  // Entry status flags
  logic [DEPTH-1:0]  r_occ;
  logic [DEPTH-1:0]  r_rdy;
  logic [DEPTH-1:0]  r_misp;

  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic              w_alloc;
  logic              w_cdb_wr;
  logic              w_byp;
  logic              w_head_rdy;
  logic              w_head_misp;
  logic [DATA_W-1:0] w_head_val;
  logic              w_head_silent;
  logic              w_retire;
  logic              w_unused_op;

  assign full        = (r_count == c_FULL);
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign alloc_ready = !full;
  assign alloc_tag   = r_tail;

  assign w_alloc  = alloc_valid && !full;
  assign w_cdb_wr = cdb_valid && r_occ[cdb_tag];

`ifdef ROB_CDB_BYPASS_EN
  assign w_byp = cdb_valid && (cdb_tag == r_head) && r_occ[r_head];
`else
  assign w_byp = 1'b0;
`endif

  // Head commit decode: purely combinational from head state (plus bypass)
  assign w_head_rdy    = r_occ[r_head] && (r_rdy[r_head] || w_byp);
  assign w_head_misp   = w_byp ? cdb_mispredict : r_misp[r_head];
  assign w_head_val    = w_byp ? cdb_data : r_val[r_head];
  assign w_head_silent = w_head_rdy && (r_type[r_head] != c_TYPE_REG)
                         && (r_type[r_head] != c_TYPE_STORE);

  assign commit_reg_valid   = w_head_rdy && (r_type[r_head] == c_TYPE_REG);
  assign commit_store_valid = w_head_rdy && (r_type[r_head] == c_TYPE_STORE);
  assign flush              = w_head_silent && w_head_misp;
  assign commit_dst         = w_head_rdy ? r_dst[r_head] : '0;
  assign commit_data        = w_head_rdy ? w_head_val : '0;

  // Mispredict flags on register/store entries do not flush; only
  // type none/reserved entries carry branch outcomes.
  assign w_retire = commit_reg_valid
                    || (commit_store_valid && store_ready)
                    || (w_head_silent && !w_head_misp);

  // Opcode is carried for debug visibility only
  assign w_unused_op = ^r_op[r_head];

  // Payload capture on allocation and CDB writeback
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_op[r_tail]   <= alloc_op;
      r_dst[r_tail]  <= alloc_dst;
      r_type[r_tail] <= alloc_dst_type;
    end
    if (w_cdb_wr) begin
      r_val[cdb_tag] <= cdb_data;
    end
  end

  // Pointers, occupancy and status flags; flush overrides everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_occ   <= '0;
      r_rdy   <= '0;
      r_misp  <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_occ   <= '0;
      r_rdy   <= '0;
      r_misp  <= '0;
    end else begin
      if (w_retire) begin
        r_occ[r_head] <= 1'b0;
        r_head        <= r_head + TAG_W'(1);
      end
      if (w_cdb_wr) begin
        r_rdy[cdb_tag]  <= 1'b1;
        r_misp[cdb_tag] <= cdb_mispredict;
      end
      if (w_alloc) begin
        r_occ[r_tail]  <= 1'b1;
        r_rdy[r_tail]  <= 1'b0;
        r_misp[r_tail] <= 1'b0;
        r_tail         <= r_tail + TAG_W'(1);
      end
      if (w_alloc && !w_retire) begin
        r_count <= r_count + (TAG_W+1)'(1);
      end else if (!w_alloc && w_retire) begin
        r_count <= r_count - (TAG_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_circ.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rob_circ                                                   |
// | Purpose  : Directed self-checking bench for rob_circ (DEPTH=4, 64-bit)   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rob_circ;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int OP_W   = 6;
  localparam int TAG_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [OP_W-1:0]   alloc_op;
  logic [DATA_W-1:0] alloc_dst;
  logic [1:0]        alloc_dst_type;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_mispredict;
  logic              commit_reg_valid;
  logic              commit_store_valid;
  logic              store_ready;
  logic [DATA_W-1:0] commit_dst;
  logic [DATA_W-1:0] commit_data;
  logic              flush;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  int n_vec = 0;
  int n_err = 0;

  rob_circ #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_dst(alloc_dst), .alloc_dst_type(alloc_dst_type), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_mispredict(cdb_mispredict),
    .commit_reg_valid(commit_reg_valid), .commit_store_valid(commit_store_valid),
    .store_ready(store_ready), .commit_dst(commit_dst), .commit_data(commit_data),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_op = '0; alloc_dst = '0; alloc_dst_type = 2'd0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; cdb_mispredict = 0;
    store_ready = 0;
  endtask

  task automatic alloc(input logic [1:0] typ, input logic [63:0] dst);
    alloc_valid = 1; alloc_dst_type = typ; alloc_dst = dst; alloc_op = 6'h2A;
  endtask

  initial begin
    int a, w, r, mc;
    logic do_alloc, do_cdb, do_ret;

    // ---------------- reset ----------------
    rst = 1; idle();
    tick(); tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_count", count, 0);
    check("rst_tag", alloc_tag, 0);
    check("rst_regv", commit_reg_valid, 0);
    check("rst_stv", commit_store_valid, 0);
    check("rst_flush", flush, 0);
    rst = 0;
    tick();

    // ---------------- fill to full, 5th alloc ignored ----------------
    for (int i = 0; i < 4; i++) begin
      alloc(2'd1, 64'(i));
      #1 check("fill_tag", alloc_tag, 64'(i));
      tick();
    end
    alloc(2'd1, 64'h99);
    #1;
    check("full_flag", full, 1);
    check("full_ready", alloc_ready, 0);
    check("full_count", count, 4);
    check("full_tag", alloc_tag, 0);
    tick();
    idle();
    #1;
    check("full5_count", count, 4);
    check("full5_tag", alloc_tag, 0);
    check("full_noretire", commit_reg_valid, 0);
    rst = 1; #1; rst = 0;
    tick();
    check("clr_count", count, 0);

    // ---------------- out-of-order completion, in-order retire ----------------
    alloc(2'd1, 64'h10); tick();
    alloc(2'd1, 64'h11); tick();
    idle();
    cdb_valid = 1; cdb_tag = 2'd1; cdb_data = 64'hBB;
    #1 check("ooo_wait1", commit_reg_valid, 0);
    tick();
    cdb_tag = 2'd0; cdb_data = 64'hAA;
    #1 check("ooo_nobyp", commit_reg_valid, 0);
    tick();
    idle();
    #1;
    check("ooo_v0", commit_reg_valid, 1);
    check("ooo_d0", commit_data, 64'hAA);
    check("ooo_dst0", commit_dst, 64'h10);
    tick();
    check("ooo_v1", commit_reg_valid, 1);
    check("ooo_d1", commit_data, 64'hBB);
    check("ooo_dst1", commit_dst, 64'h11);
    tick();
    check("ooo_empty", empty, 1);

    // ---------------- store held on store_ready ----------------
    alloc(2'd2, 64'h100);
    #1 check("st_tag", alloc_tag, 2);
    tick();
    idle();
    cdb_valid = 1; cdb_tag = 2'd2; cdb_data = 64'h55;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_hold_v", commit_store_valid, 1);
      check("st_hold_dst", commit_dst, 64'h100);
      check("st_hold_d", commit_data, 64'h55);
      check("st_hold_cnt", count, 1);
      tick();
    end
    store_ready = 1;
    #1 check("st_go_v", commit_store_valid, 1);
    tick();
    store_ready = 0;
    #1;
    check("st_done_v", commit_store_valid, 0);
    check("st_done_cnt", count, 0);

    // ---------------- mispredict flush ----------------
    alloc(2'd0, 64'h0);  tick();   // tag 3
    alloc(2'd1, 64'h20); tick();   // tag 0
    alloc(2'd1, 64'h21); tick();   // tag 1
    idle();
    cdb_valid = 1; cdb_tag = 2'd3; cdb_data = 64'h1; cdb_mispredict = 1;
    tick();
    idle();
    alloc(2'd1, 64'h22);
    cdb_valid = 1; cdb_tag = 2'd0; cdb_data = 64'h33;
    #1;
    check("fl_flush", flush, 1);
    check("fl_regv", commit_reg_valid, 0);
    check("fl_cnt_pre", count, 3);
    tick();
    idle();
    #1;
    check("fl_flush_off", flush, 0);
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_tag", alloc_tag, 0);

    // ---------------- continuous fill/retire with wrap ----------------
    a = 0; w = 0; r = 0; mc = 0;
    for (int cyc = 0; cyc < 40 && r < 10; cyc++) begin
      idle();
      do_alloc = (a < 10) && (mc < 4);
      do_cdb   = (w < a);
      do_ret   = (r < w);
      if (do_alloc) alloc(2'd1, 64'h200 + 64'(a));
      if (do_cdb) begin
        cdb_valid = 1; cdb_tag = 2'(w % 4); cdb_data = 64'h1000 + 64'(w);
      end
      #1;
      check("wr_count", count, 64'(mc));
      check("wr_ready", alloc_ready, 64'(mc < 4));
      if (do_alloc) check("wr_tag", alloc_tag, 64'(a % 4));
      check("wr_regv", commit_reg_valid, 64'(do_ret));
      if (do_ret) begin
        check("wr_data", commit_data, 64'h1000 + 64'(r));
        check("wr_dst", commit_dst, 64'h200 + 64'(r));
      end
      tick();
      if (do_alloc) a++;
      if (do_cdb) w++;
      if (do_ret) r++;
      mc = mc + (do_alloc ? 1 : 0) - (do_ret ? 1 : 0);
    end
    idle();
    check("wr_retired", 64'(r), 10);
    #1 check("wr_empty", empty, 1);

    // ---------------- reset while a store waits ----------------
    alloc(2'd2, 64'h300);
    #1 check("rs_tag", alloc_tag, 2);
    tick();
    idle();
    cdb_valid = 1; cdb_tag = 2'd2; cdb_data = 64'h77;
    tick();
    idle();
    #1 check("rs_wait_v", commit_store_valid, 1);
    rst = 1;
    #1;
    check("rs_stv", commit_store_valid, 0);
    check("rs_dst", commit_dst, 0);
    check("rs_data", commit_data, 0);
    check("rs_count", count, 0);
    check("rs_empty", empty, 1);
    check("rs_tag0", alloc_tag, 0);
    check("rs_ready", alloc_ready, 1);
    tick();
    rst = 0;
    tick();
    check("rs_after_cnt", count, 0);
    check("rs_after_stv", commit_store_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
